uart_rx_os: RTL

Parametrised oversampling UART receiver, the next generation of the team's single-format 8N1 receiver. It adds configurable data width, parity, stop-bit count and oversampling ratio, majority-vote bit sampling with false-start rejection, and error and break reporting. Received words are presented on a one-entry valid/ready holding register. It sits between the shared baud generator (which supplies `sample_tick`) and any byte-consuming logic.

---
 rtl/uart_rx_os.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: configurable data width, parity, stop bits and
// oversampling ratio, 2-of-3 majority voting, false-start rejection, error and
// break reporting, and a one-entry valid/ready holding register.
module uart_rx_os #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int unsigned M    = OVERSAMPLE / 2;
  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = $clog2(DATA_BITS);

  localparam logic [OS_W-1:0] OS_VOTE0  = OS_W'(M - 1);
  localparam logic [OS_W-1:0] OS_VOTE1  = OS_W'(M);
  localparam logic [OS_W-1:0] OS_DECIDE = OS_W'(M + 1);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  // Reject illegal configurations at elaboration
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_os: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_rx_os: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_oversample
    $error("uart_rx_os: OVERSAMPLE must be 8 or 16");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrkWait
  } state_e;

  state_e                r_state;
  logic                  r_sync1, r_sync2;
  logic [OS_W-1:0]       r_os_cnt;
  logic [BC_W-1:0]       r_bit_cnt;
  logic                  r_stop_cnt;
  logic                  r_v0, r_v1;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par_bit;
  logic                  r_perr, r_ferr, r_brk;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_valid, r_perr_out, r_ferr_out;
  logic                  r_overrun, r_break, r_busy;

  logic w_rx_s;
  logic w_vote;
  logic w_par_bad;
  logic w_first_stop_brk;
  logic w_brk;
  logic w_ferr;
  logic w_stop_last;
  logic w_free;

  assign w_rx_s = r_sync2;
  // 2-of-3 majority of the two stored samples and the current one
  assign w_vote = (r_v0 & r_v1) | (r_v0 & w_rx_s) | (r_v1 & w_rx_s);
  // Odd parity wants an odd total of ones including the parity bit
  assign w_par_bad = (PARITY == 1) ? ~(^r_shift ^ w_vote) : (^r_shift ^ w_vote);
  // Break: every data bit, the parity bit (if any) and the first stop bit low
  assign w_first_stop_brk = (r_shift == '0) & ((PARITY == 0) | ~r_par_bit) & ~w_vote;
  assign w_brk       = (r_stop_cnt == 1'b0) ? w_first_stop_brk : r_brk;
  assign w_ferr      = r_ferr | ~w_vote;
  assign w_stop_last = (r_stop_cnt == STOP_LAST);
  assign w_free      = ~r_valid | rx_ready;

  // Two-flop synchroniser on the serial line, idling high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM, counters, vote samples and the holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_v0       <= 1'b1;
      r_v1       <= 1'b1;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
      r_overrun  <= 1'b0;
      r_break    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_break   <= 1'b0;
      // Consumption; a load later in this block overrides it
      if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
      if (sample_tick) begin
        if (r_os_cnt == OS_VOTE0) r_v0 <= w_rx_s;
        if (r_os_cnt == OS_VOTE1) r_v1 <= w_rx_s;
        unique case (r_state)
          StIdle: begin
            if (!w_rx_s) begin
              r_state  <= StStart;
              r_busy   <= 1'b1;
              r_os_cnt <= OS_W'(1);
              r_perr   <= 1'b0;
              r_ferr   <= 1'b0;
              r_brk    <= 1'b0;
            end
          end
          StStart: begin
            r_os_cnt <= r_os_cnt + 1'b1;
            if (r_os_cnt == OS_DECIDE && w_vote) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else if (r_os_cnt == OS_LAST) begin
              r_state   <= StData;
              r_bit_cnt <= '0;
            end
          end
          StData: begin
            r_os_cnt <= r_os_cnt + 1'b1;
            if (r_os_cnt == OS_DECIDE) begin
              r_shift[r_bit_cnt] <= w_vote;
            end
            if (r_os_cnt == OS_LAST) begin
              if (r_bit_cnt == BC_LAST) begin
                r_state    <= (PARITY != 0) ? StParity : StStop;
                r_stop_cnt <= 1'b0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          StParity: begin
            r_os_cnt <= r_os_cnt + 1'b1;
            if (r_os_cnt == OS_DECIDE) begin
              r_par_bit <= w_vote;
              r_perr    <= w_par_bad;
            end
            if (r_os_cnt == OS_LAST) begin
              r_state    <= StStop;
              r_stop_cnt <= 1'b0;
            end
          end
          StStop: begin
            r_os_cnt <= r_os_cnt + 1'b1;
            if (r_os_cnt == OS_DECIDE) begin
              r_ferr <= w_ferr;
              if (r_stop_cnt == 1'b0) r_brk <= w_first_stop_brk;
              // Complete at the last stop vote so the next start edge is caught early
              if (w_stop_last) begin
                if (w_brk) begin
                  r_break <= 1'b1;
                  r_state <= StBrkWait;
                end else begin
                  if (w_free) begin
                    r_data     <= r_shift;
                    r_perr_out <= r_perr;
                    r_ferr_out <= w_ferr;
                    r_valid    <= 1'b1;
                  end else begin
                    r_overrun <= 1'b1;
                  end
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
                end
              end
            end
            if (r_os_cnt == OS_LAST && !w_stop_last) begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
          StBrkWait: begin
            if (w_rx_s) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign parity_err  = r_perr_out;
  assign framing_err = r_ferr_out;
  assign overrun_err = r_overrun;
  assign break_det   = r_break;
  assign busy        = r_busy;

endmodule
